// File: rtl/fetch_align_buffer.sv
// Fetch-block aligner: splits 16-bit parcel blocks into RVC/32-bit instructions, joins straddlers,
// queues them in a circular buffer. Optional predecode flags are built when FETCH_PREDECODE_EN is defined.
module fetch_align_buffer #(
  parameter int FETCH_WIDTH  = 4,
  parameter int BLOCK_HALVES = 16,
  parameter int BUF_DEPTH    = 32,
  parameter int FTQIDX_W     = 4,
  parameter int OFFSET_W     = $clog2(2*BLOCK_HALVES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_squash_vld,
  input  logic                            i_blk_vld,
  output logic                            o_blk_rdy,
  input  logic [16*BLOCK_HALVES-1:0]      i_blk_data,
  input  logic [$clog2(BLOCK_HALVES):0]   i_blk_size,
  input  logic [FTQIDX_W-1:0]             i_blk_ftqIdx,
  input  logic                            i_blk_except,
  input  logic                            i_backend_rdy,
  output logic [FETCH_WIDTH-1:0]          o_inst_vld,
  output logic [32*FETCH_WIDTH-1:0]       o_inst,
  output logic [FTQIDX_W*FETCH_WIDTH-1:0] o_inst_ftqIdx,
  output logic [OFFSET_W*FETCH_WIDTH-1:0] o_inst_ftqOffset,
  output logic [FETCH_WIDTH-1:0]          o_inst_except,
  output logic [3*FETCH_WIDTH-1:0]        o_inst_predecode,
  output logic [$clog2(BUF_DEPTH):0]      o_count
);
  localparam int IDX_W  = $clog2(BUF_DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int CNT_W  = IDX_W + 1;
  localparam int RANK_W = $clog2(BLOCK_HALVES) + 1;

  typedef struct packed {
    logic [31:0]         inst;
    logic [FTQIDX_W-1:0] ftq;
    logic [OFFSET_W-1:0] off;
    logic                except;
  } entry_t;

  logic [PTR_W-1:0]        head, tail;
  logic [CNT_W-1:0]        count, n_out, deq_n;
  logic                    carry_vld;
  logic [15:0]             carry_lo;
  logic [FTQIDX_W-1:0]     carry_ftq;
  logic [OFFSET_W-1:0]     carry_off;
  logic [BLOCK_HALVES-1:0] s1_vld, st_vld;
  entry_t                  s1_ent [BLOCK_HALVES];
  entry_t                  st_ent [BLOCK_HALVES];
  logic                    s1_carry_vld;
  logic [15:0]             s1_carry_lo;
  logic [OFFSET_W-1:0]     s1_carry_off;
  logic [IDX_W-1:0]        wr_pos [BLOCK_HALVES];
  logic [RANK_W-1:0]       st_pending;
  logic                    accept;
  entry_t                  mem [BUF_DEPTH];

  assign o_blk_rdy = (BUF_DEPTH - int'(count) - int'(st_pending)) >= BLOCK_HALVES;
  assign accept    = i_blk_vld && o_blk_rdy && !i_squash_vld;
  assign n_out     = (count > CNT_W'(FETCH_WIDTH)) ? CNT_W'(FETCH_WIDTH) : count;
  assign deq_n     = i_backend_rdy ? n_out : '0;
  assign o_count   = count;

  // Stage 1: one slot per starting parcel; slot 0 carries the merged straddler when a carry is pending.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    logic [15:0] parcel [BLOCK_HALVES+1];
    logic        prev_long;
    for (int k = 0; k < BLOCK_HALVES; k++) parcel[k] = i_blk_data[16*k +: 16];
    parcel[BLOCK_HALVES] = '0;
    s1_vld       = '0;
    for (int k = 0; k < BLOCK_HALVES; k++) s1_ent[k] = '0;
    s1_carry_vld = 1'b0;
    s1_carry_lo  = '0;
    s1_carry_off = '0;
    prev_long    = carry_vld;
    if (i_blk_except) begin
      s1_vld[0]        = 1'b1;
      s1_ent[0].ftq    = i_blk_ftqIdx;
      s1_ent[0].except = 1'b1;
    end else begin
      if (carry_vld) begin
        s1_vld[0]      = 1'b1;
        s1_ent[0].inst = {parcel[0], carry_lo};
        s1_ent[0].ftq  = carry_ftq;
        s1_ent[0].off  = carry_off;
      end
      for (int k = 0; k < BLOCK_HALVES; k++) begin
        if (k < int'(i_blk_size)) begin
          if (prev_long) begin
            prev_long = 1'b0;
          end else begin
            prev_long = (parcel[k][1:0] == 2'b11);
            if (prev_long && k == int'(i_blk_size) - 1) begin
              s1_carry_vld = 1'b1;
              s1_carry_lo  = parcel[k];
              s1_carry_off = OFFSET_W'(2*k);
            end else begin
              s1_vld[k]      = 1'b1;
              s1_ent[k].inst = prev_long ? {parcel[k+1], parcel[k]} : {16'h0, parcel[k]};
              s1_ent[k].ftq  = i_blk_ftqIdx;
              s1_ent[k].off  = OFFSET_W'(2*k);
            end
          end
        end
      end
    end
  end

  // Stage 2: compact valid slots onto consecutive buffer positions starting at tail.
  always_comb begin
    logic [RANK_W-1:0] rank;
    rank = '0;
    for (int k = 0; k < BLOCK_HALVES; k++) begin
      wr_pos[k] = IDX_W'(tail[IDX_W-1:0] + IDX_W'(rank));
      if (st_vld[k]) rank = rank + 1'b1;
    end
    st_pending = rank;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      carry_vld <= 1'b0;
      st_vld    <= '0;
    end else if (i_squash_vld) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      carry_vld <= 1'b0;
      st_vld    <= '0;
    end else begin
      head   <= head + PTR_W'(deq_n);
      tail   <= tail + PTR_W'(st_pending);
      count  <= count + CNT_W'(st_pending) - deq_n;
      st_vld <= accept ? s1_vld : '0;
      if (accept) carry_vld <= s1_carry_vld;
    end
  end

  // NOTE: payload registers and the entry memory are not reset; valid bits and pointers qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      st_ent    <= s1_ent;
      carry_lo  <= s1_carry_lo;
      carry_ftq <= i_blk_ftqIdx;
      carry_off <= s1_carry_off;
    end
    for (int k = 0; k < BLOCK_HALVES; k++)
      if (st_vld[k] && !i_squash_vld) mem[wr_pos[k]] <= st_ent[k];
  end

`ifdef FETCH_PREDECODE_EN
  logic [2:0] s1_pd  [BLOCK_HALVES];
  logic [2:0] st_pd  [BLOCK_HALVES];
  logic [2:0] pd_mem [BUF_DEPTH];

  // {isJal, isBr, isRet} for both 32-bit and compressed encodings.
  function automatic logic [2:0] predecode(input logic [31:0] inst);
    logic is_jal, is_br, is_ret;
    if (inst[1:0] == 2'b11) begin
      is_jal = (inst[6:0] == 7'b1101111);
      is_br  = (inst[6:0] == 7'b1100011);
      is_ret = (inst[6:0] == 7'b1100111) && (inst[11:7] == 5'd0) && (inst[19:15] == 5'd1);
    end else begin
      is_jal = (inst[1:0] == 2'b01) && (inst[15:13] == 3'b101 || inst[15:13] == 3'b001);
      is_br  = (inst[1:0] == 2'b01) && (inst[15:14] == 2'b11);
      is_ret = (inst[1:0] == 2'b10) && (inst[15:12] == 4'b1000) && (inst[11:7] == 5'd1)
               && (inst[6:2] == 5'd0);
    end
    return {is_jal, is_br, is_ret};
  endfunction

  always_comb
    for (int k = 0; k < BLOCK_HALVES; k++) s1_pd[k] = predecode(s1_ent[k].inst);

  always_ff @(posedge clk) begin
    if (accept) st_pd <= s1_pd;
    for (int k = 0; k < BLOCK_HALVES; k++)
      if (st_vld[k] && !i_squash_vld) pd_mem[wr_pos[k]] <= st_pd[k];
  end
`endif

  always_comb begin
    logic [IDX_W-1:0] rd_idx;
    o_inst_vld       = '0;
    o_inst           = '0;
    o_inst_ftqIdx    = '0;
    o_inst_ftqOffset = '0;
    o_inst_except    = '0;
    o_inst_predecode = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      rd_idx = IDX_W'(head[IDX_W-1:0] + IDX_W'(i));
      if (CNT_W'(i) < n_out) begin
        o_inst_vld[i]                       = 1'b1;
        o_inst[32*i +: 32]                  = mem[rd_idx].inst;
        o_inst_ftqIdx[FTQIDX_W*i +: FTQIDX_W] = mem[rd_idx].ftq;
        o_inst_ftqOffset[OFFSET_W*i +: OFFSET_W] = mem[rd_idx].off;
        o_inst_except[i]                    = mem[rd_idx].except;
`ifdef FETCH_PREDECODE_EN
        o_inst_predecode[3*i +: 3]          = pd_mem[rd_idx];
`endif
      end
    end
  end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// Self-checking bench for fetch_align_buffer: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_fetch_align_buffer;
  localparam int FW = 4, BH = 16, BD = 32, FTQ_W = 4, OFF_W = 5;

  logic                  clk = 1'b0, rst = 1'b1;
  logic                  i_squash_vld = 1'b0, i_blk_vld = 1'b0, o_blk_rdy;
  logic [16*BH-1:0]      i_blk_data = '0;
  logic [4:0]            i_blk_size = '0;
  logic [FTQ_W-1:0]      i_blk_ftqIdx = '0;
  logic                  i_blk_except = 1'b0, i_backend_rdy = 1'b0;
  logic [FW-1:0]         o_inst_vld, o_inst_except;
  logic [32*FW-1:0]      o_inst;
  logic [FTQ_W*FW-1:0]   o_inst_ftqIdx;
  logic [OFF_W*FW-1:0]   o_inst_ftqOffset;
  logic [3*FW-1:0]       o_inst_predecode;
  logic [5:0]            o_count;

  always #5 clk = ~clk;

  fetch_align_buffer dut (
    .clk(clk), .rst(rst), .i_squash_vld(i_squash_vld), .i_blk_vld(i_blk_vld),
    .o_blk_rdy(o_blk_rdy), .i_blk_data(i_blk_data), .i_blk_size(i_blk_size),
    .i_blk_ftqIdx(i_blk_ftqIdx), .i_blk_except(i_blk_except), .i_backend_rdy(i_backend_rdy),
    .o_inst_vld(o_inst_vld), .o_inst(o_inst), .o_inst_ftqIdx(o_inst_ftqIdx),
    .o_inst_ftqOffset(o_inst_ftqOffset), .o_inst_except(o_inst_except),
    .o_inst_predecode(o_inst_predecode), .o_count(o_count)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entry packing {inst, ftqIdx, offset, except}
  function automatic logic [41:0] mk(input logic [31:0] inst, input logic [3:0] ftq,
                                     input int off, input logic exc);
    return {inst, ftq, 5'(off), exc};
  endfunction

  function automatic logic [41:0] slot(input int i);
    return {o_inst[32*i +: 32], o_inst_ftqIdx[FTQ_W*i +: FTQ_W],
            o_inst_ftqOffset[OFF_W*i +: OFF_W], o_inst_except[i]};
  endfunction

  function automatic logic [3:0] therm(input int n);
    return 4'((1 << n) - 1);
  endfunction

  // Current block being presented
  logic [15:0] bp [BH];
  int          bsize;
  logic [3:0]  bftq;
  logic        bexc;

  task automatic drive_blk();
    i_blk_vld = 1'b1;
    for (int k = 0; k < BH; k++) i_blk_data[16*k +: 16] = bp[k];
    i_blk_size   = 5'(bsize);
    i_blk_ftqIdx = bftq;
    i_blk_except = bexc;
  endtask

  // Parcels 4..15 follow 1+4k (all compressed) so a full-size block is 16 RVC instructions.
  task automatic present_blk(input int size, input logic [15:0] p0, p1, p2, p3,
                             input logic [3:0] ftq, input logic exc);
    @(negedge clk);
    bp[0] = p0; bp[1] = p1; bp[2] = p2; bp[3] = p3;
    for (int k = 4; k < BH; k++) bp[k] = 16'(1 + 4*k);
    bsize = size; bftq = ftq; bexc = exc;
    drive_blk();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_blk_vld = 1'b0;
    end
  endtask

  task automatic squash();
    @(negedge clk);
    i_blk_vld    = 1'b0;
    i_squash_vld = 1'b1;
    @(negedge clk);
    i_squash_vld = 1'b0;
  endtask

  // Reference model: expected instruction stream built from the block splitting rules.
  logic [41:0] exp_q [$];
  logic        m_carry = 1'b0;
  logic [15:0] m_lo;
  logic [3:0]  m_ftq;
  int          m_off;

  task automatic model_accept();
    int k;
    if (bexc) begin
      exp_q.push_back(mk(32'h0, bftq, 0, 1'b1));
      m_carry = 1'b0;
      return;
    end
    k = 0;
    if (m_carry) begin
      exp_q.push_back(mk({bp[0], m_lo}, m_ftq, m_off, 1'b0));
      m_carry = 1'b0;
      k = 1;
    end
    while (k < bsize) begin
      if (bp[k][1:0] != 2'b11) begin
        exp_q.push_back(mk({16'h0, bp[k]}, bftq, 2*k, 1'b0));
        k += 1;
      end else if (k == bsize - 1) begin
        m_carry = 1'b1; m_lo = bp[k]; m_ftq = bftq; m_off = 2*k;
        k += 1;
      end else begin
        exp_q.push_back(mk({bp[k+1], bp[k]}, bftq, 2*k, 1'b0));
        k += 2;
      end
    end
  endtask

  typedef struct {
    string       name;
    int          size;
    logic [15:0] p0, p1, p2, p3;
    logic [3:0]  ftq;
    logic        exc;
    int          exp_n;
    logic [41:0] exp0, exp1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{"rvc16",   16, 16'h0001, 16'h0005, 16'h0009, 16'h000d, 4'd1, 1'b0, 16,
                mk(32'h1, 4'd1, 0, 1'b0), mk(32'h5, 4'd1, 2, 1'b0)};
    vecs[1] = '{"except",  4, 16'h0001, 16'h0002, 16'h0003, 16'h0013, 4'd5, 1'b1, 1,
                mk(32'h0, 4'd5, 0, 1'b1), '0};
    vecs[2] = '{"two32",   4, 16'h0013, 16'h00aa, 16'h0063, 16'h0bb0, 4'd2, 1'b0, 2,
                mk(32'h00aa0013, 4'd2, 0, 1'b0), mk(32'h0bb00063, 4'd2, 4, 1'b0)};
    vecs[3] = '{"size1",   1, 16'h4422, 16'hffff, 16'hffff, 16'hffff, 4'd3, 1'b0, 1,
                mk(32'h4422, 4'd3, 0, 1'b0), '0};
    vecs[4] = '{"mix",     3, 16'h0001, 16'h1233, 16'h5678, 16'h0013, 4'd7, 1'b0, 2,
                mk(32'h1, 4'd7, 0, 1'b0), mk(32'h56781233, 4'd7, 2, 1'b0)};
    vecs[5] = '{"carry",   1, 16'h0013, 16'h0001, 16'h0001, 16'h0001, 4'd4, 1'b0, 0, '0, '0};
    vecs[6] = '{"fresh",   1, 16'h0005, 16'h0001, 16'h0001, 16'h0001, 4'd6, 1'b0, 1,
                mk(32'h5, 4'd6, 0, 1'b0), '0};

    // Reset state
    #2;
    check("rst_vld", o_inst_vld, 0);
    check("rst_count", o_count, 0);
    check("rst_rdy", o_blk_rdy, 1);
    check("rst_inst", o_inst, 0);
    #10 rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", o_blk_rdy, 1);

    // Table: each vector into an empty buffer, backend stalled
    foreach (vecs[v]) begin
      squash();
      i_backend_rdy = 1'b0;
      present_blk(vecs[v].size, vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3,
                  vecs[v].ftq, vecs[v].exc);
      idle(2);
      check({vecs[v].name, "_count"}, o_count, vecs[v].exp_n);
      check({vecs[v].name, "_vld"}, o_inst_vld, therm(vecs[v].exp_n > FW ? FW : vecs[v].exp_n));
      if (vecs[v].exp_n >= 1) check({vecs[v].name, "_slot0"}, slot(0), vecs[v].exp0);
      if (vecs[v].exp_n >= 2) check({vecs[v].name, "_slot1"}, slot(1), vecs[v].exp1);
    end

    // 16 RVC delivered 4 per cycle starting two cycles after acceptance
    squash();
    i_backend_rdy = 1'b1;
    present_blk(16, 16'h0001, 16'h0005, 16'h0009, 16'h000d, 4'd9, 1'b0);
    idle(1);
    check("deliv_n1_vld", o_inst_vld, 0);
    for (int c = 0; c < 4; c++) begin
      idle(1);
      check("deliv_vld", o_inst_vld, 4'hf);
      for (int i = 0; i < FW; i++) begin
        int k;
        k = 4*c + i;
        check("deliv_slot", slot(i), mk(32'(1 + 4*k), 4'd9, 2*k, 1'b0));
      end
    end
    idle(1);
    check("deliv_empty_count", o_count, 0);
    check("deliv_empty_vld", o_inst_vld, 0);

    // Straddle across two blocks
    squash();
    i_backend_rdy = 1'b0;
    present_blk(3, 16'h0001, 16'h0005, 16'h0013, 16'h0000, 4'd2, 1'b0);
    present_blk(3, 16'h1234, 16'h0009, 16'h000d, 16'h0000, 4'd3, 1'b0);
    idle(2);
    check("strad_count", o_count, 5);
    check("strad_s0", slot(0), mk(32'h1, 4'd2, 0, 1'b0));
    check("strad_s1", slot(1), mk(32'h5, 4'd2, 2, 1'b0));
    check("strad_s2", slot(2), mk(32'h12340013, 4'd2, 4, 1'b0));
    check("strad_s3", slot(3), mk(32'h9, 4'd3, 2, 1'b0));
    i_backend_rdy = 1'b1;
    idle(1);
    i_backend_rdy = 1'b0;
    check("strad_rest_count", o_count, 1);
    check("strad_rest_s0", slot(0), mk(32'hd, 4'd3, 4, 1'b0));

    // Fill to capacity with backend stalled
    squash();
    present_blk(16, 16'h0001, 16'h0005, 16'h0009, 16'h000d, 4'd1, 1'b0);
    present_blk(16, 16'h0001, 16'h0005, 16'h0009, 16'h000d, 4'd2, 1'b0);
    check("fill_second_rdy", o_blk_rdy, 1);
    idle(1);
    check("fill_pending_rdy", o_blk_rdy, 0);
    idle(1);
    check("fill_count", o_count, 32);
    check("fill_rdy", o_blk_rdy, 0);
    i_backend_rdy = 1'b1;
    idle(1);
    i_backend_rdy = 1'b0;
    check("fill_deq_count", o_count, 28);
    check("fill_deq_rdy", o_blk_rdy, 0);

    // Squash with carry valid and a block presented in the same cycle
    squash();
    present_blk(1, 16'h0013, 16'h0000, 16'h0000, 16'h0000, 4'd4, 1'b0);
    present_blk(2, 16'h0001, 16'h0005, 16'h0000, 16'h0000, 4'd9, 1'b0);
    i_squash_vld = 1'b1;
    @(negedge clk);
    i_squash_vld = 1'b0;
    i_blk_vld    = 1'b0;
    check("sq_vld", o_inst_vld, 0);
    check("sq_count", o_count, 0);
    check("sq_rdy", o_blk_rdy, 1);
    present_blk(1, 16'h0021, 16'h0000, 16'h0000, 16'h0000, 4'd8, 1'b0);
    idle(2);
    check("sq_fresh_count", o_count, 1);
    check("sq_fresh_s0", slot(0), mk(32'h21, 4'd8, 0, 1'b0));

    // Exception block drops a pending carry
    squash();
    present_blk(1, 16'h0013, 16'h0000, 16'h0000, 16'h0000, 4'd4, 1'b0);
    present_blk(4, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 4'd5, 1'b1);
    present_blk(1, 16'h0021, 16'h0000, 16'h0000, 16'h0000, 4'd6, 1'b0);
    idle(2);
    check("exc_count", o_count, 2);
    check("exc_s0", slot(0), mk(32'h0, 4'd5, 0, 1'b1));
    check("exc_s1", slot(1), mk(32'h21, 4'd6, 0, 1'b0));

    // Randomized run against the reference model
    squash();
    exp_q.delete();
    m_carry = 1'b0;
    begin
      int  done, cyc;
      bit  have;
      logic [31:0] r;
      done = 0; cyc = 0; have = 0;
      while ((done < 100 || exp_q.size() != 0) && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        check("rnd_therm", o_inst_vld, therm($countones(o_inst_vld)));
        for (int i = 0; i < FW; i++) begin
          if (o_inst_vld[i]) begin
            if (i < exp_q.size()) begin
              check("rnd_slot", slot(i), exp_q[i]);
            end else begin
              checks++;
              errors++;
              $display("FAIL rnd_extra: slot %0d valid %0h with empty model queue", i, slot(i));
            end
          end
        end
        i_backend_rdy = 1'($urandom_range(0, 1));
        if (i_backend_rdy)
          repeat ($countones(o_inst_vld)) if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (!have && done < 100 && $urandom_range(0, 3) != 0) begin
          bsize = $urandom_range(1, BH);
          bftq  = 4'(done);
          bexc  = ($urandom_range(0, 15) == 0);
          for (int k = 0; k < BH; k++) begin
            r = $urandom;
            bp[k] = {r[15:2], ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 2))};
          end
          have = 1;
        end
        if (have) begin
          drive_blk();
          if (o_blk_rdy) begin
            model_accept();
            have = 0;
            done++;
          end
        end else begin
          i_blk_vld = 1'b0;
        end
      end
      check("rnd_blocks", done, 100);
      check("rnd_queue_empty", exp_q.size(), 0);
      idle(1);
      check("rnd_final_count", o_count, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
